// File: rtl/reg32_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : reg32_serializer                                              |
// | Function : 32-bit parallel-to-serial shifter with valid/ready handshake, |
// |            bit 0 first; define PARITY_EN to append an even-parity bit.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module reg32_serializer (
  input  logic        clk,
  input  logic        res,
  input  logic [0:31] data_in,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic        ser_ready,
  output logic        ser_out,
  output logic        ser_valid,
  output logic        frame_start,
  output logic        frame_end
);

  localparam logic [4:0] C_LAST_BIT = 5'd31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef PARITY_EN
    , PAR = 2'd2
`endif
  } state_t;

  state_t      r_state, w_state;
  logic [1:31] r_shift, w_shift;
  logic [4:0]  r_count, w_count;
  logic        r_ser_out, w_ser_out;
  logic        r_ser_valid, w_ser_valid;
`ifdef PARITY_EN
  logic        r_par, w_par;
`endif
  logic        w_final;
  logic        w_accept;

  // w_final marks the cycle presenting the last bit of the frame
`ifdef PARITY_EN
  assign w_final = (r_state == PAR);
`else
  assign w_final = (r_state == SHIFT) && (r_count == C_LAST_BIT);
`endif

  assign load_ready  = res && ((r_state == IDLE) || (w_final && ser_ready));
  assign w_accept    = load_valid && load_ready;
  assign frame_start = (r_state == SHIFT) && (r_count == 5'd0);
  assign frame_end   = w_final;
  assign ser_out     = r_ser_out;
  assign ser_valid   = r_ser_valid;

  always_comb begin
    w_state     = r_state;
    w_shift     = r_shift;
    w_count     = r_count;
    w_ser_out   = r_ser_out;
    w_ser_valid = r_ser_valid;
`ifdef PARITY_EN
    w_par       = r_par;
`endif
    if (w_accept) begin
      // bit 0 goes straight to the output register; the rest wait in r_shift
      w_state     = SHIFT;
      w_shift     = data_in[1:31];
      w_count     = 5'd0;
      w_ser_out   = data_in[0];
      w_ser_valid = 1'b1;
`ifdef PARITY_EN
      w_par       = ^data_in;
`endif
    end else if (ser_ready) begin
      case (r_state)
        SHIFT: begin
          if (r_count != C_LAST_BIT) begin
            w_count   = r_count + 5'd1;
            w_ser_out = r_shift[1];
            w_shift   = {r_shift[2:31], 1'b0};
          end else begin
`ifdef PARITY_EN
            w_state   = PAR;
            w_ser_out = r_par;
`else
            w_state     = IDLE;
            w_ser_out   = 1'b0;
            w_ser_valid = 1'b0;
`endif
          end
        end
`ifdef PARITY_EN
        PAR: begin
          w_state     = IDLE;
          w_ser_out   = 1'b0;
          w_ser_valid = 1'b0;
        end
`endif
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_count     <= 5'd0;
      r_ser_out   <= 1'b0;
      r_ser_valid <= 1'b0;
`ifdef PARITY_EN
      r_par       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state;
      r_shift     <= w_shift;
      r_count     <= w_count;
      r_ser_out   <= w_ser_out;
      r_ser_valid <= w_ser_valid;
`ifdef PARITY_EN
      r_par       <= w_par;
`endif
    end
  end

endmodule
`default_nettype wire

// File: doc/reg32_serializer.md
REG32_SERIALIZER -- requirements
Module: reg32_serializer

Interface
REQ-001 clk  input  1  single clock; all state changes on posedge clk except reset.
REQ-002 res  input  1  reset, asynchronous, active-low.
REQ-003 data_in  input  [0:31]  parallel word to transmit; bit 0 is sent first.
REQ-004 load_valid  input  1  data_in holds a word to be loaded.
REQ-005 load_ready  output  1  block can accept a word this cycle.
REQ-006 ser_ready  input  1  downstream accepts the current serial bit this cycle.
REQ-007 ser_out  output  1  current serial bit, registered.
REQ-008 ser_valid  output  1  ser_out holds a valid bit.
REQ-009 frame_start  output  1  high while the first bit of a frame is presented.
REQ-010 frame_end  output  1  high while the last bit of a frame is presented.

Function
REQ-011 The block SHALL use the states IDLE, SHIFT and PAR; PAR exists only with PARITY_EN.
REQ-012 A word SHALL be accepted on a posedge where load_valid=1 and load_ready=1; the whole 32-bit data_in is captured in one cycle.
REQ-013 load_ready SHALL be 1 in IDLE, and also in the final-bit cycle of a frame (SHIFT with count=31 and no parity, or PAR) when ser_ready=1; it SHALL be 0 otherwise.
REQ-014 On acceptance, the state SHALL move to SHIFT; ser_valid=1 and ser_out=data_in[0] SHALL appear in the cycle after acceptance, which is a latency of 1.
REQ-015 In SHIFT, a posedge with ser_ready=1 SHALL advance to the next bit, where bit k is sent while the 5-bit count = k.
REQ-016 When ser_ready=0, ser_out, ser_valid, count and state SHALL hold unchanged.
REQ-017 frame_start SHALL be 1 only while count=0 in SHIFT; frame_end SHALL be 1 only while the last bit of the frame is presented.
REQ-018 After the last bit is taken with ser_ready=1 and no new load, the state SHALL return to IDLE with ser_valid=0 and ser_out=0.
REQ-019 After the last bit is taken with ser_ready=1 and load_valid=1 in the same cycle, the next frame's bit 0 SHALL follow with no idle gap.
REQ-020 load_valid while load_ready=0 SHALL be ignored; the frame in progress is not disturbed.
REQ-021 data_in changes after acceptance SHALL NOT affect the frame in progress.
REQ-022 The count SHALL NOT wrap to 0 inside a frame; it clears only on a new acceptance.

Reset
REQ-023 When res=0, the block SHALL enter IDLE asynchronously and clear the shift register, count and parity.
REQ-024 While res=0, the outputs SHALL be load_ready=0, ser_out=0, ser_valid=0, frame_start=0 and frame_end=0.
REQ-025 After res deasserts, load_ready SHALL be 1 from the first posedge.
REQ-026 A frame interrupted by reset SHALL be discarded and never resumed.

Configuration
REQ-027 Macro PARITY_EN defined: after bit 31, the PAR state SHALL send 1 extra bit, the even parity (XOR) of the 32 captured bits.
REQ-028 With PARITY_EN, frame_end SHALL mark the parity bit, and the frame length SHALL be 33 bits.
REQ-029 Without PARITY_EN: no PAR state; the frame is 32 bits and frame_end marks bit 31.

Verification
REQ-030 Load 32'hA5A5_0F0F with ser_ready=1 constantly -> ser_out over 32 cycles = 1,0,1,0,0,1,0,1,... data_in[0..31] in order; frame_start on cycle 1, frame_end on cycle 32, then IDLE.
REQ-031 Load 32'hFFFF_FFFF, hold ser_ready=0 for 5 cycles at bit 10 -> ser_out=1 and count=10 are held; the frame completes 5 cycles late with all 32 bits intact.
REQ-032 Back-to-back: 32'h0000_0001 then 32'h8000_0000, second load_valid held -> 64 consecutive ser_valid cycles with no gap; second frame begins with bit 0 = 1.
REQ-033 res=0 pulse mid-frame at bit 17 -> outputs clear immediately without a clock; load_ready=1 after release; a new word then transmits from bit 0.
REQ-034 PARITY_EN, load 32'h0000_0007 -> 33rd bit = 1 with frame_end=1; load 32'h0000_0003 -> 33rd bit = 0.
REQ-035 load_valid pulsed with 32'h1234_5678 while busy -> ignored; the current frame's bits and length are unchanged.
